// File: rtl/lcd_pkg.sv
// Constants and state encoding shared by the HD44780 read and write paths.
`default_nettype none

package lcd_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    BF_SET = 4'd1,
    BF_EN  = 4'd2,
    AD_SET = 4'd3,
    AD_EN  = 4'd4,
    AD_HLD = 4'd5,
    RD_SET = 4'd6,
    RD_EN  = 4'd7,
    DONE   = 4'd8
  } lcd_rd_state_t;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam int         LCD_BF_BIT        = 7;

  // Bus values whenever no LCD access is in progress
  localparam logic       LCD_RS_REST = 1'b0;
  localparam logic       LCD_RW_REST = 1'b0;
  localparam logic       LCD_E_REST  = 1'b0;
  localparam logic       LCD_OE_REST = 1'b0;
  localparam logic [7:0] LCD_DB_REST = 8'h00;

endpackage

`default_nettype wire

// File: rtl/read_ascii_lcd.sv
// Reads one DDRAM character from an HD44780 LCD: busy poll, Set-DDRAM-Address,
// data read, then returns the byte over a valid/ready handshake.
`default_nettype none

module read_ascii_lcd
  import lcd_pkg::*;
#(
  parameter int BUSY_POLLS = 8
) (
  input  logic       clk_1024,
  input  logic       reset_n,
  input  logic       rd_req,
  input  logic [6:0] rd_addr,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_err,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in
);

  localparam logic [3:0] POLL_MAX = 4'(BUSY_POLLS);

  lcd_rd_state_t state;
  logic [3:0]    polls;
  logic [6:0]    addr;

  // Every output is registered and updated together with the state, so bus
  // control lines only move on the edge where E is (or goes) low.
  always_ff @(posedge clk_1024 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      polls      <= 4'd0;
      addr       <= 7'd0;
      rd_ready   <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
      rd_err     <= 1'b0;
      lcd_rs     <= LCD_RS_REST;
      lcd_rw     <= LCD_RW_REST;
      lcd_e      <= LCD_E_REST;
      lcd_db_out <= LCD_DB_REST;
      lcd_db_oe  <= LCD_OE_REST;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            addr     <= rd_addr;
            polls    <= 4'd0;
            rd_ready <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_rw   <= 1'b1;
            lcd_db_oe <= 1'b0;
            state    <= BF_SET;
          end
        end
        BF_SET: begin
          polls <= polls + 4'd1;
          lcd_e <= 1'b1;
          state <= BF_EN;
        end
        BF_EN: begin
          lcd_e <= 1'b0;
          if (!lcd_db_in[LCD_BF_BIT]) begin
            lcd_rw     <= 1'b0;
            lcd_db_oe  <= 1'b1;
            lcd_db_out <= LCD_CMD_SET_DDRAM | {1'b0, addr};
            state      <= AD_SET;
          end else if (polls < POLL_MAX) begin
            state <= BF_SET;
          end else begin
            rd_err     <= 1'b1;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b1;
            lcd_rs     <= LCD_RS_REST;
            lcd_rw     <= LCD_RW_REST;
            lcd_db_oe  <= LCD_OE_REST;
            lcd_db_out <= LCD_DB_REST;
            state      <= DONE;
          end
        end
        AD_SET: begin
          lcd_e <= 1'b1;
          state <= AD_EN;
        end
        AD_EN: begin
          lcd_e <= 1'b0;
          state <= AD_HLD;
        end
        AD_HLD: begin
          // Release the bus before the LCD starts driving it
          lcd_rs     <= 1'b1;
          lcd_rw     <= 1'b1;
          lcd_db_oe  <= 1'b0;
          lcd_db_out <= LCD_DB_REST;
          state      <= RD_SET;
        end
        RD_SET: begin
          lcd_e <= 1'b1;
          state <= RD_EN;
        end
        RD_EN: begin
          lcd_e     <= 1'b0;
          rd_data   <= lcd_db_in;
          rd_err    <= 1'b0;
          rd_valid  <= 1'b1;
          lcd_rs    <= LCD_RS_REST;
          lcd_rw    <= LCD_RW_REST;
          lcd_db_oe <= LCD_OE_REST;
          state     <= DONE;
        end
        DONE: begin
          rd_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          lcd_e      <= LCD_E_REST;
          lcd_rs     <= LCD_RS_REST;
          lcd_rw     <= LCD_RW_REST;
          lcd_db_oe  <= LCD_OE_REST;
          lcd_db_out <= LCD_DB_REST;
          rd_ready   <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_read_ascii_lcd.sv
// Scoreboard bench for read_ascii_lcd against a small HD44780 bus model.
`default_nettype none

module tb_read_ascii_lcd;

  localparam int BP = 8;

  logic       clk_1024 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       rd_req   = 1'b0;
  logic [6:0] rd_addr  = 7'd0;
  wire        rd_ready, rd_valid, rd_err;
  wire  [7:0] rd_data;
  wire        lcd_rs, lcd_rw, lcd_e, lcd_db_oe;
  wire  [7:0] lcd_db_out;
  wire  [7:0] lcd_db_in;

  read_ascii_lcd #(.BUSY_POLLS(BP)) dut (
    .clk_1024  (clk_1024),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db_out(lcd_db_out),
    .lcd_db_oe (lcd_db_oe),
    .lcd_db_in (lcd_db_in)
  );

  always #5 clk_1024 = ~clk_1024;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // LCD model
  logic [7:0] ddram [128];
  logic [6:0] ac = 7'd0;
  int         busy_left = 0;
  logic       busy_forever = 1'b0;
  int         bf_reads = 0;
  int         addr_writes = 0;
  logic [7:0] last_cmd = 8'h00;
  logic       cap_rs, cap_rw;
  logic [7:0] cap_db;
  wire        model_busy = busy_forever || (busy_left > 0);

  assign lcd_db_in = (lcd_e && lcd_rw) ? (lcd_rs ? ddram[ac] : {model_busy, ac}) : 8'hFF;

  always @(posedge lcd_e) begin
    cap_rs = lcd_rs;
    cap_rw = lcd_rw;
    cap_db = lcd_db_out;
  end

  always @(negedge lcd_e) begin
    if (cap_rw && !cap_rs) begin
      bf_reads++;
      if (busy_left > 0) busy_left--;
    end else if (!cap_rw && !cap_rs) begin
      addr_writes++;
      last_cmd = cap_db;
      if (cap_db[7]) ac = cap_db[6:0];
    end
  end

  // Scoreboard and monitors
  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb[$];
  int   acc_cycs[$];
  int   valid_cycs[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   proto_viol = 0;
  logic prev_rs = 1'b0, prev_rw = 1'b0, prev_valid = 1'b0;
  logic [7:0] prev_db = 8'h00;

  always @(posedge clk_1024) cyc++;

  always @(negedge clk_1024) begin
    if (reset_n && rd_req && rd_ready) begin
      acc_cyc = cyc;
      acc_cycs.push_back(cyc);
    end
    if (rd_valid) begin
      valid_cycs.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", {24'd0, rd_data}, {24'd0, e.data});
        check("rd_err", {31'd0, rd_err}, {31'd0, e.err});
        check("latency", cyc - acc_cyc, e.lat);
      end
    end
    if (lcd_e && ({lcd_rs, lcd_rw, lcd_db_out} != {prev_rs, prev_rw, prev_db})) proto_viol++;
    if (lcd_rw && lcd_db_oe) proto_viol++;
    if (rd_valid && prev_valid) proto_viol++;
    prev_rs = lcd_rs;
    prev_rw = lcd_rw;
    prev_db = lcd_db_out;
    prev_valid = rd_valid;
  end

  task automatic expect_rd(input logic [7:0] d, input logic err, input int lat);
    exp_t e;
    e.data = d;
    e.err  = err;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [6:0] a);
    @(posedge clk_1024) #2;
    rd_req  = 1'b1;
    rd_addr = a;
    @(posedge clk_1024) #2;
    rd_req  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_1024);
      n++;
    end
    check(tag, sb.size(), 0);
    repeat (3) @(negedge clk_1024);
  endtask

  task automatic clear_counts();
    bf_reads = 0;
    addr_writes = 0;
    acc_cycs.delete();
    valid_cycs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) ddram[i] = 8'h00;
    ddram[7'h05] = 8'h41;
    ddram[7'h40] = 8'h5A;
    ddram[7'h00] = 8'h10;
    ddram[7'h01] = 8'h20;
    ddram[7'h68] = 8'h33;

    // Reset state
    repeat (3) @(negedge clk_1024);
    check("rst_ready", rd_ready, 1);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_err", rd_err, 0);
    check("rst_bus", {lcd_rs, lcd_rw, lcd_e, lcd_db_oe, lcd_db_out}, 0);
    @(posedge clk_1024) #2 reset_n = 1'b1;
    repeat (2) @(negedge clk_1024);

    // Idle LCD
    clear_counts();
    expect_rd(8'h41, 1'b0, 8);
    issue(7'h05);
    drain("t1_drain");
    check("t1_bf_reads", bf_reads, 1);
    check("t1_addr_writes", addr_writes, 1);
    check("t1_cmd", last_cmd, 8'h85);
    repeat (4) @(negedge clk_1024);
    check("t1_data_hold", rd_data, 8'h41);

    // Busy for three polls, with a stray request while busy
    clear_counts();
    busy_left = 3;
    expect_rd(8'h5A, 1'b0, 14);
    issue(7'h40);
    @(posedge clk_1024) #2;
    rd_req = 1'b1;
    rd_addr = 7'h05;
    repeat (3) @(posedge clk_1024);
    #2 rd_req = 1'b0;
    drain("t2_drain");
    check("t2_bf_reads", bf_reads, 4);
    check("t2_cmd", last_cmd, 8'hC0);
    check("t2_accepts", acc_cycs.size(), 1);

    // Permanently busy: timeout
    clear_counts();
    busy_forever = 1'b1;
    expect_rd(8'h00, 1'b1, 2 * BP + 1);
    issue(7'h10);
    drain("t3_drain");
    check("t3_bf_reads", bf_reads, BP);
    check("t3_addr_writes", addr_writes, 0);
    busy_forever = 1'b0;

    // Out-of-range address passes through unchanged
    clear_counts();
    expect_rd(8'h33, 1'b0, 8);
    issue(7'h68);
    drain("t4_drain");
    check("t4_cmd", last_cmd, 8'hE8);

    // Back-to-back with rd_req held high
    clear_counts();
    expect_rd(8'h10, 1'b0, 8);
    expect_rd(8'h20, 1'b0, 8);
    @(posedge clk_1024) #2;
    rd_req = 1'b1;
    rd_addr = 7'h00;
    @(posedge clk_1024) #2;
    rd_addr = 7'h01;
    for (int n = 0; n < 100 && acc_cycs.size() < 2; n++) @(negedge clk_1024);
    @(posedge clk_1024) #2 rd_req = 1'b0;
    drain("t5_drain");
    check("t5_accepts", acc_cycs.size(), 2);
    if (acc_cycs.size() == 2 && valid_cycs.size() >= 1)
      check("t5_reaccept_gap", acc_cycs[1] - valid_cycs[0], 1);
    else
      check("t5_reaccept_gap", 32'hFFFF_FFFF, 1);

    // Reset asserted during the address E pulse
    clear_counts();
    @(posedge clk_1024) #2;
    rd_req = 1'b1;
    rd_addr = 7'h07;
    @(posedge clk_1024) #2 rd_req = 1'b0;
    begin
      int n;
      n = 0;
      while (!(lcd_e && lcd_db_oe) && n < 50) begin
        @(negedge clk_1024);
        n++;
      end
      check("t6_reach_ad_en", {lcd_e, lcd_db_oe}, 2'b11);
    end
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_e", lcd_e, 0);
    check("t6_async_oe", lcd_db_oe, 0);
    sb.delete();
    @(posedge clk_1024) #2 reset_n = 1'b1;
    @(negedge clk_1024);
    check("t6_ready", rd_ready, 1);
    clear_counts();
    expect_rd(8'h41, 1'b0, 8);
    issue(7'h05);
    drain("t6_drain");
    check("t6_cmd", last_cmd, 8'h85);

    check("protocol", proto_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
